// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Optional feature macro: SEQDIV_DBZ_CHECK_EN (early exit on a zero divisor).
package seq_div_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TRIAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

`ifdef SEQDIV_DBZ_CHECK_EN
    localparam bit DBZ_CHECK = 1'b1;
`else
    localparam bit DBZ_CHECK = 1'b0;
`endif

    // Width of the bit index counter; never narrower than one bit.
    function automatic int idx_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_divider_ctrl.sv
// Sequencer for the restoring divider: walks LOAD -> (SHIFT, TRIAL) x WIDTH -> DONE
// and issues one-hot strobes to the datapath held in the top level.
// With SEQDIV_DBZ_CHECK_EN the first SHIFT exits straight to DONE on a zero divisor.
//
// Handshake: start is sampled only in IDLE; busy is high in LOAD/SHIFT/TRIAL;
// done is high for exactly the single DONE cycle, when results are already valid.
module seq_divider_ctrl
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  logic   dbz,
    output logic   ld,
    output logic   shift_en,
    output logic   trial_en,
    output logic   last,
    output logic   dbz_done,
    output logic   busy,
    output logic   done,
    output state_t state
);

    localparam int IDX_W = idx_width(WIDTH);

    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;

    // State and bit index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state, index update and datapath strobes.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ld        = 1'b0;
        shift_en  = 1'b0;
        trial_en  = 1'b0;
        last      = 1'b0;
        dbz_done  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy      = 1'b1;
                ld        = 1'b1;
                idx_nxt   = IDX_W'(WIDTH - 1);
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                // The zero test looks at the captured divisor, so it lands here.
                if (DBZ_CHECK && dbz) begin
                    dbz_done  = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    shift_en  = 1'b1;
                    state_nxt = S_TRIAL;
                end
            end
            S_TRIAL: begin
                busy     = 1'b1;
                trial_en = 1'b1;
                if (idx == '0) begin
                    last      = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = idx - IDX_W'(1);
                    state_nxt = S_SHIFT;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit every two cycles.
// Datapath (partial remainder, dividend shift register, divisor, results) lives here;
// sequencing is in seq_divider_ctrl. Macro SEQDIV_DBZ_CHECK_EN enables the
// zero-divisor early exit and the div_zero flag (otherwise div_zero stays 0).
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int STATE_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       dividend,
    input  logic [WIDTH-1:0]       divisor,
    output logic [WIDTH-1:0]       quotient,
    output logic [WIDTH-1:0]       remainder,
    output logic                   busy,
    output logic                   done,
    output logic                   div_zero,
    output logic [STATE_WIDTH-1:0] dbg_state
);

    logic [WIDTH:0]   p;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic             dz_q;
    logic             ld, shift_en, trial_en, last, dbz_done;
    state_t           state;

    // Trial subtract on WIDTH+1 bits; the MSB is the borrow.
    assign diff      = p - {1'b0, dvs_reg};
    assign div_zero  = dz_q;
    assign dbg_state = STATE_WIDTH'(state);

    seq_divider_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dbz      (dvs_reg == '0),
        .ld       (ld),
        .shift_en (shift_en),
        .trial_en (trial_en),
        .last     (last),
        .dbz_done (dbz_done),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    // Datapath: capture, shift in dividend bits, trial-subtract, commit results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p         <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz_q      <= 1'b0;
        end else begin
            if (ld) begin
                dvd_reg   <= dividend;
                dvs_reg   <= divisor;
                p         <= '0;
                quotient  <= '0;
                remainder <= '0;
                dz_q      <= 1'b0;
            end
            if (shift_en) begin
                p       <= {p[WIDTH-1:0], dvd_reg[WIDTH-1]};
                dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
            end
            if (trial_en) begin
                // Quotient fills from the LSB, so after WIDTH trials bit i sits at i.
                quotient <= {quotient[WIDTH-2:0], ~diff[WIDTH]};
                if (!diff[WIDTH]) p <= diff;
                // Remainder is written with the last trial so it is valid alongside done.
                if (last) remainder <= diff[WIDTH] ? p[WIDTH-1:0] : diff[WIDTH-1:0];
            end
            if (dbz_done) begin
                quotient  <= '1;
                remainder <= dvd_reg;
                dz_q      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=4) with hand-computed expectations,
// plus an exhaustive operand sweep against a small reference model.
module tb_seq_divider;

    localparam int W = 4;

`ifdef SEQDIV_DBZ_CHECK_EN
    localparam int DBZ_LAT = 2;
    localparam bit DBZ_EN  = 1'b1;
`else
    localparam int DBZ_LAT = 9;
    localparam bit DBZ_EN  = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [2:0]   dbg_state;

    int n_vec = 0;
    int n_bad = 0;

    seq_divider #(.WIDTH(W), .STATE_WIDTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog in case the bench itself stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation starting from IDLE: start is high for edge E0 only.
    // Returns in the cycle after the done cycle (IDLE again).
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                         input logic exp_dz, input int exp_lat);
        int lat;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();                       // E0
        start = 1'b0;
        tick();                       // E0+1 : LOAD cycle
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_q"}, 32'(quotient), 32'(exp_q));
        check({tag, "_r"}, 32'(remainder), 32'(exp_r));
        check({tag, "_dz"}, 32'(div_zero), 32'(exp_dz));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int       done_k[$];
        logic [W-1:0] rq, rr;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic divide.
        do_op("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 9);

        // Back-to-back: second start is high in the cycle after done.
        do_op("d15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 9);
        do_op("d0_5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 9);

        // Divide by zero.
        do_op("d7_0", 4'd7, 4'd0, 4'd15, 4'd7, DBZ_EN, DBZ_LAT);

        // Results hold while idle.
        repeat (3) tick();
        check("hold_q", 32'(quotient), 32'd15);
        check("hold_r", 32'(remainder), 32'd7);

        // Start held high for 20 edges; operands wiggle after each LOAD.
        dividend = 4'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();                   // edge E0+k
            if (done) begin
                done_k.push_back(k);
                check("hold9_2_q", 32'(quotient), 32'd4);
                check("hold9_2_r", 32'(remainder), 32'd1);
            end
            if (k == 19) start = 1'b0;
            if (k == 2 || k == 13) begin
                dividend = 4'd15;
                divisor  = 4'd1;
            end
            if (k == 8 || k == 21) begin
                dividend = 4'd9;
                divisor  = 4'd2;
            end
        end
        check("hold_ops", 32'(done_k.size()), 32'd2);
        if (done_k.size() == 2) begin
            check("hold_first_k", 32'(done_k[0]), 32'd9);
            check("hold_second_k", 32'(done_k[1]), 32'd20);
        end

        // Reset during a TRIAL cycle of 14/4.
        dividend = 4'd14;
        divisor  = 4'd4;
        start    = 1'b1;
        tick();                       // E0
        start = 1'b0;
        tick();                       // LOAD
        tick();                       // SHIFT -> now in TRIAL
        check("abort_in_trial", 32'(dbg_state), 32'd3);
        rst_n = 1'b0;
        tick();
        check("abort_q", 32'(quotient), 32'd0);
        check("abort_r", 32'(remainder), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dz", 32'(div_zero), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) check("abort_no_done", 32'(done), 32'd0);
        end
        do_op("d14_4", 4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 9);

        // Exhaustive sweep against the reference model.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    rq = 4'hF;
                    rr = 4'(a);
                end else begin
                    rq = 4'(a / b);
                    rr = 4'(a % b);
                end
                do_op("sweep", 4'(a), 4'(b), rq, rr, (b == 0) && DBZ_EN,
                      (b == 0) ? DBZ_LAT : 9);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
